// File: rtl/bls12_381_fe12_collect_if.sv
// Bus between the pairing wrapper's serial Fp12 stream, the collector and
// the parallel fe12 consumer.
//   slave  : the collector (takes beats, produces fe12 results)
//   master : the surrounding logic (drives beats, consumes fe12 results)
// Signals:
//   i_fe_val/o_fe_rdy, i_fe_dat, i_fe_sop, i_fe_eop, i_fe_ctl : serial beat stream
//   o_fe12_val/i_fe12_rdy, o_fe12, o_fe12_ctl                : parallel result
//   o_err, o_err_cnt                                         : malformed-packet reporting
interface bls12_381_fe12_collect_if #(
  parameter int unsigned CTL_BITS = 84,
  parameter int unsigned DAT_BITS = 381,
  parameter int unsigned N_WORDS  = 12
);

  logic                         i_fe_val;
  logic                         o_fe_rdy;
  logic [DAT_BITS-1:0]          i_fe_dat;
  logic                         i_fe_sop;
  logic                         i_fe_eop;
  logic [CTL_BITS-1:0]          i_fe_ctl;

  logic                         o_fe12_val;
  logic                         i_fe12_rdy;
  logic [N_WORDS*DAT_BITS-1:0]  o_fe12;
  logic [CTL_BITS-1:0]          o_fe12_ctl;

  logic                         o_err;
  logic [7:0]                   o_err_cnt;

  modport slave (
    input  i_fe_val, i_fe_dat, i_fe_sop, i_fe_eop, i_fe_ctl, i_fe12_rdy,
    output o_fe_rdy, o_fe12_val, o_fe12, o_fe12_ctl, o_err, o_err_cnt
  );

  modport master (
    output i_fe_val, i_fe_dat, i_fe_sop, i_fe_eop, i_fe_ctl, i_fe12_rdy,
    input  o_fe_rdy, o_fe12_val, o_fe12, o_fe12_ctl, o_err, o_err_cnt
  );

endinterface

// File: rtl/bls12_381_fe12_collect.sv
// Reassembles the pairing wrapper's serial Fp12 result (N_WORDS Fp words,
// one per beat, framed by sop/eop) into a single parallel fe12 word with a
// valid/ready handshake. Malformed packets (short, long, missing sop,
// aborted by an early sop) are dropped and reported on o_err / o_err_cnt.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   bus (slave)  beat stream in (val/rdy/dat/sop/eop/ctl), fe12 result out
//                (val/rdy/fe12/ctl), o_err pulse and saturating o_err_cnt
//
// Optional feature (macro BLS12_381_FE12_COLLECT_RANGE_CHK_EN):
//   when defined, every accepted word is compared against bls12_381_pkg::P;
//   a packet holding any word >= P is discarded at eop with one o_err pulse.
//   When undefined no comparator exists and word values are not checked.
module bls12_381_fe12_collect #(
  parameter int unsigned CTL_BITS = 84,
  parameter int unsigned DAT_BITS = 381,
  parameter int unsigned N_WORDS  = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  bls12_381_fe12_collect_if.slave bus
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ERR_W     = 8;
  localparam int unsigned FE12_BITS = N_WORDS * DAT_BITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 acc_c;
  logic                 wr_en_c;
  logic [CNT_W-1:0]     wr_slot_c;
  logic                 ctl_en_c;
  logic                 err_d;
  logic                 pkt_bad_c;

  logic [FE12_BITS-1:0] fe12_q;
  logic [CTL_BITS-1:0]  ctl_q;
  logic                 err_q;
  logic [ERR_W-1:0]     err_cnt_q;

  // Beats are only taken while not holding a result.
  assign acc_c = bus.i_fe_val && (state_q != ST_OUT);

`ifdef BLS12_381_FE12_COLLECT_RANGE_CHK_EN
  logic beat_bad_c;
  logic pkt_bad_q;

  assign beat_bad_c = (bus.i_fe_dat >= bls12_381_pkg::P);

  // Sticky out-of-range flag for the packet in flight; a sop restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_bad_q <= 1'b0;
    end else if (acc_c) begin
      pkt_bad_q <= bus.i_fe_sop ? beat_bad_c : (pkt_bad_q | beat_bad_c);
    end
  end

  // Badness including the beat currently being accepted.
  assign pkt_bad_c = bus.i_fe_sop ? beat_bad_c : (pkt_bad_q | beat_bad_c);
`else
  assign pkt_bad_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, word counter and datapath strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_c   = 1'b0;
    wr_slot_c = cnt_q;
    ctl_en_c  = 1'b0;
    err_d     = 1'b0;

    if (acc_c) begin
      if (bus.i_fe_sop) begin
        // A sop always restarts the packet; a nonzero count means the
        // previous packet was cut short. In DRAIN the count is already 0.
        wr_en_c   = 1'b1;
        wr_slot_c = '0;
        ctl_en_c  = 1'b1;
        err_d     = (cnt_q != '0);
        state_d   = ST_COLLECT;
        if (bus.i_fe_eop) begin
          cnt_d = '0;
          if ((LAST_CNT == '0) && !pkt_bad_c) begin
            state_d = ST_OUT;
          end else begin
            err_d = 1'b1;
          end
        end else if (LAST_CNT == '0) begin
          // Single-word packets: a sop without eop is already too long.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end else if (state_q == ST_DRAIN) begin
        // Discard silently until the tail of the bad packet.
        if (bus.i_fe_eop) begin
          state_d = ST_COLLECT;
        end
      end else if (cnt_q == '0) begin
        // Beat with no preceding sop: drop it and skip to the next eop.
        err_d = 1'b1;
        if (!bus.i_fe_eop) begin
          state_d = ST_DRAIN;
        end
      end else begin
        wr_en_c = 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (bus.i_fe_eop && !pkt_bad_c) begin
            state_d = ST_OUT;
          end else begin
            // Long packet (no eop on the last slot) or out-of-range word.
            err_d = 1'b1;
            if (!bus.i_fe_eop) begin
              state_d = ST_DRAIN;
            end
          end
        end else if (bus.i_fe_eop) begin
          // Short packet.
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if ((state_q == ST_OUT) && bus.i_fe12_rdy) begin
      state_d = ST_COLLECT;
    end
  end

  // Output decode; everything except o_fe_rdy comes straight from flops.
  always_comb begin
    bus.o_fe_rdy   = (state_q != ST_OUT);
    bus.o_fe12_val = (state_q == ST_OUT);
    bus.o_fe12     = fe12_q;
    bus.o_fe12_ctl = ctl_q;
    bus.o_err      = err_q;
    bus.o_err_cnt  = err_cnt_q;
  end

  // Result buffer, captured ctl and error reporting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fe12_q    <= '0;
      ctl_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= err_d;
      if (err_d && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
      if (ctl_en_c) begin
        ctl_q <= bus.i_fe_ctl;
      end
      for (int unsigned n = 0; n < N_WORDS; n++) begin
        if (wr_en_c && (wr_slot_c == CNT_W'(n))) begin
          fe12_q[n*DAT_BITS +: DAT_BITS] <= bus.i_fe_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_bls12_381_fe12_collect.sv
// Self-checking bench for bls12_381_fe12_collect: table of packet shapes,
// hand sequences for backpressure / reset / range / saturation, and a random
// packet stream checked against a packet-level reference model.
module tb_bls12_381_fe12_collect;

  localparam int unsigned CTL_BITS  = 84;
  localparam int unsigned DAT_BITS  = 381;
  localparam int unsigned N_WORDS   = 12;
  localparam int unsigned FE12_BITS = N_WORDS * DAT_BITS;
  localparam logic [DAT_BITS-1:0] P_VAL =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  typedef struct {
    logic [FE12_BITS-1:0] dat;
    logic [CTL_BITS-1:0]  ctl;
  } res_t;

  typedef struct {
    int                  nb;
    bit                  sop_first;
    int                  sop2;
    logic [DAT_BITS-1:0] base;
    logic [CTL_BITS-1:0] ctl;
    int                  exp_out;
    int                  exp_err;
    int                  word0;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bls12_381_fe12_collect_if #(.CTL_BITS(CTL_BITS), .DAT_BITS(DAT_BITS), .N_WORDS(N_WORDS)) bus ();

  bls12_381_fe12_collect #(.CTL_BITS(CTL_BITS), .DAT_BITS(DAT_BITS), .N_WORDS(N_WORDS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   err_seen = 0;
  int   exp_errs = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_force = 1'b1;
  res_t got_q[$];
  res_t exp_q[$];

  // Observe results and error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_err) err_seen++;
      if (bus.o_fe12_val && bus.i_fe12_rdy) got_q.push_back('{bus.o_fe12, bus.o_fe12_ctl});
    end
  end

  // Downstream ready driver.
  initial begin
    bus.i_fe12_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.i_fe12_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input res_t act, input res_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (act.ctl !== exp.ctl)
        $display("FAIL %s: ctl got %h expected %h", name, act.ctl, exp.ctl);
      else
        for (int n = 0; n < N_WORDS; n++)
          if (act.dat[n*DAT_BITS +: DAT_BITS] !== exp.dat[n*DAT_BITS +: DAT_BITS]) begin
            $display("FAIL %s: word %0d got %h expected %h", name, n,
                     act.dat[n*DAT_BITS +: DAT_BITS], exp.dat[n*DAT_BITS +: DAT_BITS]);
            break;
          end
    end
  endtask

  function automatic res_t exp_seq(input logic [DAT_BITS-1:0] base, input logic [CTL_BITS-1:0] c);
    res_t r;
    for (int n = 0; n < N_WORDS; n++) r.dat[n*DAT_BITS +: DAT_BITS] = base + DAT_BITS'(n);
    r.ctl = c;
    return r;
  endfunction

  function automatic logic [DAT_BITS-1:0] rand_word();
    logic [383:0] w;
    for (int i = 0; i < 12; i++) w[i*32 +: 32] = $urandom;
    w[383:377] = '0;
    return w[DAT_BITS-1:0];
  endfunction

  function automatic logic [CTL_BITS-1:0] rand_ctl();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[CTL_BITS-1:0];
  endfunction

  function automatic int sat255(input int e);
    return (e > 255) ? 255 : e;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Entered just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input logic [DAT_BITS-1:0] d, input bit s, input bit e,
                           input logic [CTL_BITS-1:0] c, input int gap);
    int guard;
    bus.i_fe_val = 1'b0;
    wait_cycles(gap);
    bus.i_fe_dat = d;
    bus.i_fe_sop = s;
    bus.i_fe_eop = e;
    bus.i_fe_ctl = c;
    bus.i_fe_val = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.o_fe_rdy && guard < 400) begin @(negedge clk); guard++; end
    if (!bus.o_fe_rdy) begin
      n_cmp++; n_err++;
      $display("FAIL beat_accept_timeout: o_fe_rdy got 0 for %0d cycles, expected 1", guard);
    end
    @(posedge clk); #1;
    bus.i_fe_val = 1'b0;
    bus.i_fe_sop = 1'b0;
    bus.i_fe_eop = 1'b0;
  endtask

  task automatic send_pkt(input logic [DAT_BITS-1:0] base, input logic [CTL_BITS-1:0] c,
                          input int nb, input bit sop_first, input int sop2,
                          input int maxgap, input bit with_eop);
    for (int b = 0; b < nb; b++)
      send_beat(base + DAT_BITS'(b), (b == 0 && sop_first) || (b == sop2),
                with_eop && (b == nb - 1), c ^ CTL_BITS'(b), $urandom_range(0, maxgap));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    wait_cycles(n);
    rst = 1'b0;
    exp_errs = 0;
  endtask

  vec_t tbl[11];
  res_t r_a, r_b, r_exp;
  logic [FE12_BITS-1:0] snap;
  int e0, bad_rdy, bad_hold, guard, kind, nb;
  bit b_done, prev_abort;
  logic [DAT_BITS-1:0] base;
  logic [CTL_BITS-1:0] c;

  initial begin
    tbl[0]  = '{nb:12, sop_first:1, sop2:-1, base:1,    ctl:'h5A,  exp_out:1, exp_err:0, word0:0};
    tbl[1]  = '{nb:6,  sop_first:1, sop2:-1, base:100,  ctl:'h11,  exp_out:0, exp_err:1, word0:0};
    tbl[2]  = '{nb:12, sop_first:1, sop2:-1, base:200,  ctl:'h22,  exp_out:1, exp_err:0, word0:0};
    tbl[3]  = '{nb:14, sop_first:1, sop2:-1, base:250,  ctl:'h33,  exp_out:0, exp_err:1, word0:0};
    tbl[4]  = '{nb:12, sop_first:1, sop2:-1, base:300,  ctl:'h44,  exp_out:1, exp_err:0, word0:0};
    tbl[5]  = '{nb:16, sop_first:1, sop2:4,  base:400,  ctl:'h55,  exp_out:1, exp_err:1, word0:4};
    tbl[6]  = '{nb:3,  sop_first:0, sop2:-1, base:450,  ctl:'h66,  exp_out:0, exp_err:1, word0:0};
    tbl[7]  = '{nb:1,  sop_first:1, sop2:-1, base:470,  ctl:'h77,  exp_out:0, exp_err:1, word0:0};
    tbl[8]  = '{nb:1,  sop_first:0, sop2:-1, base:480,  ctl:'h88,  exp_out:0, exp_err:1, word0:0};
    tbl[9]  = '{nb:12, sop_first:1, sop2:-1, base:500,  ctl:'h99,  exp_out:1, exp_err:0, word0:0};
    tbl[10] = '{nb:14, sop_first:0, sop2:2,  base:600,  ctl:'hAA,  exp_out:1, exp_err:1, word0:2};

    rst = 1'b1;
    bus.i_fe_val = 1'b0; bus.i_fe_sop = 1'b0; bus.i_fe_eop = 1'b0;
    bus.i_fe_dat = '0;   bus.i_fe_ctl = '0;
    @(posedge clk); #1;
    do_reset(3);
    wait_cycles(1);
    chk("reset_fe12_val", bus.o_fe12_val, 0);
    chk("reset_fe_rdy", bus.o_fe_rdy, 1);
    chk("reset_err", bus.o_err, 0);
    chk("reset_err_cnt", bus.o_err_cnt, 0);

    // Nominal packet, one-cycle latency, then held result under backpressure.
    rdy_force = 1'b0;
    wait_cycles(2);
    got_q.delete(); e0 = err_seen;
    for (int b = 0; b < 11; b++) send_beat(DAT_BITS'(b + 1), b == 0, 1'b0, CTL_BITS'('h5A) ^ CTL_BITS'(b), 0);
    @(negedge clk);
    chk("pre_eop_fe12_val", bus.o_fe12_val, 0);
    @(posedge clk); #1;
    send_beat(DAT_BITS'(12), 1'b0, 1'b1, CTL_BITS'('h5A) ^ CTL_BITS'(11), 0);
    @(negedge clk);
    chk("latency_fe12_val", bus.o_fe12_val, 1);
    chk_res("nominal_result", '{bus.o_fe12, bus.o_fe12_ctl}, exp_seq(DAT_BITS'(1), CTL_BITS'('h5A)));
    snap = bus.o_fe12;
    r_a = exp_seq(DAT_BITS'(1), CTL_BITS'('h5A));
    r_b = exp_seq(DAT_BITS'(1000), CTL_BITS'('h77));
    b_done = 1'b0;
    fork
      begin
        @(posedge clk); #1;
        send_pkt(DAT_BITS'(1000), CTL_BITS'('h77), 12, 1'b1, -1, 0, 1'b1);
        b_done = 1'b1;
      end
    join_none
    bad_rdy = 0; bad_hold = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_fe_rdy !== 1'b0) bad_rdy++;
      if (bus.o_fe12 !== snap || bus.o_fe12_val !== 1'b1) bad_hold++;
    end
    chk("bp_fe_rdy_high_cycles", bad_rdy, 0);
    chk("bp_result_unstable_cycles", bad_hold, 0);
    rdy_force = 1'b1;
    guard = 0;
    while (!b_done && guard < 300) begin wait_cycles(1); guard++; end
    chk("bp_second_pkt_done", b_done, 1);
    wait_cycles(4);
    chk("bp_result_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk_res("bp_first_result", got_q[0], r_a);
      chk_res("bp_second_result", got_q[1], r_b);
    end
    chk("bp_err_pulses", err_seen - e0, 0);

    // Packet-shape table.
    for (int i = 0; i < 11; i++) begin
      got_q.delete(); e0 = err_seen;
      send_pkt(tbl[i].base, tbl[i].ctl, tbl[i].nb, tbl[i].sop_first, tbl[i].sop2, 1, 1'b1);
      wait_cycles(4);
      chk($sformatf("vec%0d_out_count", i), got_q.size(), tbl[i].exp_out);
      if (tbl[i].exp_out != 0 && got_q.size() > 0)
        chk_res($sformatf("vec%0d_result", i), got_q[0],
                exp_seq(tbl[i].base + DAT_BITS'(tbl[i].word0), tbl[i].ctl ^ CTL_BITS'(tbl[i].word0)));
      chk($sformatf("vec%0d_err_pulses", i), err_seen - e0, tbl[i].exp_err);
      exp_errs += tbl[i].exp_err;
    end
    chk("table_err_cnt", bus.o_err_cnt, sat255(exp_errs));

    // Random packet stream against a packet-level model.
    rdy_rand = 1'b1;
    got_q.delete(); exp_q.delete(); e0 = err_seen;
    prev_abort = 1'b0;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 4);
      if (prev_abort && (kind == 1 || kind == 3)) kind = 0;
      if (k == 39) kind = 0;
      base = rand_word();
      c = rand_ctl();
      prev_abort = 1'b0;
      case (kind)
        0: begin send_pkt(base, c, 12, 1'b1, -1, 2, 1'b1); exp_q.push_back(exp_seq(base, c)); end
        1: begin nb = $urandom_range(1, 11); send_pkt(base, c, nb, 1'b1, -1, 2, 1'b1); exp_errs++; end
        2: begin nb = $urandom_range(13, 16); send_pkt(base, c, nb, 1'b1, -1, 2, 1'b1); exp_errs++; end
        3: begin nb = $urandom_range(1, 3); send_pkt(base, c, nb, 1'b0, -1, 2, 1'b1); exp_errs++; end
        default: begin
          nb = $urandom_range(1, 11); send_pkt(base, c, nb, 1'b1, -1, 2, 1'b0);
          exp_errs++; prev_abort = 1'b1;
        end
      endcase
    end
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 2000) begin wait_cycles(1); guard++; end
    wait_cycles(4);
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    wait_cycles(2);
    chk("rand_result_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk_res($sformatf("rand_result%0d", i), got_q[i], exp_q[i]);
    chk("rand_err_cnt", bus.o_err_cnt, sat255(exp_errs));

    // Word equal to P: dropped only when the range check is built in.
    got_q.delete(); e0 = err_seen;
    r_exp = exp_seq(DAT_BITS'(2000), CTL_BITS'('h3C));
    r_exp.dat[3*DAT_BITS +: DAT_BITS] = P_VAL;
    for (int b = 0; b < 12; b++)
      send_beat((b == 3) ? P_VAL : DAT_BITS'(2000 + b), b == 0, b == 11, CTL_BITS'('h3C), 0);
    wait_cycles(4);
`ifdef BLS12_381_FE12_COLLECT_RANGE_CHK_EN
    chk("range_out_count", got_q.size(), 0);
    chk("range_err_pulses", err_seen - e0, 1);
    exp_errs++;
`else
    chk("range_out_count", got_q.size(), 1);
    if (got_q.size() > 0) chk_res("range_result", got_q[0], r_exp);
    chk("range_err_pulses", err_seen - e0, 0);
`endif

    // Reset in the middle of a packet.
    got_q.delete(); e0 = err_seen;
    for (int b = 0; b < 7; b++) send_beat(DAT_BITS'(3000 + b), b == 0, 1'b0, CTL_BITS'('h12), 0);
    bus.i_fe_dat = DAT_BITS'(3007); bus.i_fe_val = 1'b1;
    do_reset(2);
    bus.i_fe_val = 1'b0;
    wait_cycles(3);
    chk("rst_mid_out_count", got_q.size(), 0);
    chk("rst_mid_err_pulses", err_seen - e0, 0);
    chk("rst_mid_err_cnt", bus.o_err_cnt, 0);
    send_pkt(DAT_BITS'(3100), CTL_BITS'('h13), 12, 1'b1, -1, 0, 1'b1);
    wait_cycles(3);
    chk("rst_mid_next_count", got_q.size(), 1);
    if (got_q.size() > 0) chk_res("rst_mid_next_result", got_q[0], exp_seq(DAT_BITS'(3100), CTL_BITS'('h13)));

    // Reset while a result is pending.
    rdy_force = 1'b0;
    wait_cycles(2);
    got_q.delete(); e0 = err_seen;
    send_pkt(DAT_BITS'(3200), CTL_BITS'('h14), 12, 1'b1, -1, 0, 1'b1);
    wait_cycles(2);
    chk("rst_out_pending_val", bus.o_fe12_val, 1);
    do_reset(1);
    rdy_force = 1'b1;
    wait_cycles(3);
    chk("rst_out_val_cleared", bus.o_fe12_val, 0);
    chk("rst_out_count", got_q.size(), 0);
    chk("rst_out_err_pulses", err_seen - e0, 0);
    chk("rst_out_err_cnt", bus.o_err_cnt, 0);

    // Error counter saturation.
    e0 = err_seen;
    for (int i = 0; i < 260; i++) send_beat(DAT_BITS'(i), 1'b0, 1'b1, CTL_BITS'(0), 0);
    exp_errs += 260;
    wait_cycles(3);
    chk("sat_err_pulses", err_seen - e0, 260);
    chk("sat_err_cnt", bus.o_err_cnt, sat255(exp_errs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++; n_err++;
    $display("FAIL watchdog: simulation time got %0t, expected completion earlier", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bls12_381_fe12_collect.md
Name: bls12_381_fe12_collect

Overview:
- Downstream neighbour of bls12_381_pairing_wrapper.
- Consumes the wrapper's serial Fp12 result stream: 12 Fp words, one per beat, framed by sop/eop.
- Reassembles the words into one parallel fe12 word with valid/ready, for the final-exponentiation stage or the host return path.
- Detects malformed packets and drops them.

Parameters:
- CTL_BITS, 84, width of the sideband ctl field carried through unchanged.
- DAT_BITS, 381, width of one Fp element.
- N_WORDS, 12, number of Fp words per Fp12 packet (fixed for BLS12-381).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous to i_clk, active-high.
- i_fe_val  in  1  input beat valid.
- o_fe_rdy  out  1  input beat ready.
- i_fe_dat  in  DAT_BITS  Fp word; word n holds f[i][j][k] with n = i*6+j*2+k.
- i_fe_sop  in  1  first beat of packet.
- i_fe_eop  in  1  last beat of packet.
- i_fe_ctl  in  CTL_BITS  sideband; sampled on the sop beat only.
- o_fe12_val  out  1  parallel result valid.
- i_fe12_rdy  in  1  downstream ready.
- o_fe12  out  N_WORDS*DAT_BITS  result; word n at [n*DAT_BITS +: DAT_BITS].
- o_fe12_ctl  out  CTL_BITS  ctl captured from the sop beat.
- o_err  out  1  one-cycle pulse per dropped or malformed packet.
- o_err_cnt  out  8  saturating count of o_err pulses.

Behaviour:
- Beat accepted when i_fe_val & o_fe_rdy. o_fe_rdy = (state != OUT), combinational from the state register.
- Word counter cnt is 4 bits, range 0..N_WORDS-1. The accepted word is written to slot cnt; cnt then increments.
- State COLLECT:
  - Accepted beat with sop: write slot 0, capture ctl, cnt=1. A sop is honoured at any cnt.
  - If cnt != 0 when that sop arrives, pulse o_err once (aborted packet) and restart the packet.
  - Accepted beat without sop while cnt==0: discard the beat, pulse o_err, go to DRAIN unless that beat has eop.
  - Beat with eop and cnt==N_WORDS-1 (and no sop, or sop with N_WORDS==1): write the slot, cnt=0, go to OUT.
  - Beat with eop and cnt<N_WORDS-1 (short packet): discard the packet, pulse o_err, cnt=0, stay in COLLECT.
  - Beat at cnt==N_WORDS-1 without eop (long packet): discard the packet, pulse o_err, cnt=0, go to DRAIN.
- State DRAIN:
  - Accept and discard beats; o_fe_rdy stays high.
  - Accepted beat with eop -> COLLECT.
  - Accepted beat with sop -> handled exactly as a sop in COLLECT.
  - No further o_err pulses while in DRAIN.
- State OUT:
  - o_fe12_val = 1; o_fe12 and o_fe12_ctl held stable.
  - On i_fe12_rdy -> COLLECT next cycle. o_fe_rdy rises the cycle after the handshake.
- Latency: eop beat accepted in cycle t -> o_fe12_val high in cycle t+1. Minimum packet spacing is 13 cycles.
- Throughput: single buffer; no overlap between output hold and input collection.
- Reset values:
  - State COLLECT, cnt=0, o_fe12_val=0, o_err=0, o_err_cnt=0.
  - o_fe12 and o_fe12_ctl are don't-care (implementation zeroes them).
- Reset mid-packet or during OUT: the partial packet or pending result is silently lost; no o_err.
- o_err_cnt saturates at 255; it does not wrap.
- The data register is written only on accepted beats.

Optional Feature:
- Macro: BLS12_381_FE12_COLLECT_RANGE_CHK_EN.
- Defined: each accepted data beat is compared against bls12_381_pkg::P. Any word >= P marks the packet bad.
  - At eop the packet is discarded instead of entering OUT.
  - o_err pulses once at eop, and the block returns to COLLECT.
- Undefined: no comparator is synthesised; word values are not checked.

Test Plan:
- Nominal: 12 beats with words n+1 (n=0..11), sop on beat 0, eop on beat 11, ctl=84'h5A -> o_fe12_val one cycle after eop; o_fe12[n*381 +: 381] == n+1; o_fe12_ctl==84'h5A; o_err never pulses.
- Backpressure: i_fe12_rdy held 0 for 20 cycles after the result appears -> o_fe_rdy=0 throughout; o_fe12 stable; a second packet is presented and stalls; after rdy rises the second result matches its input.
- Short packet: eop on beat 5 -> no o_fe12_val; one o_err pulse; o_err_cnt==1. The next good packet completes correctly.
- Long packet: 14 beats with eop on beat 13 -> o_err pulses once at beat 11; beats 12-13 drained; no output. The next good packet completes.
- Sop mid-packet plus reset: sop reasserted at beat 4 -> o_err pulses once; 12 beats from the new sop yield a correct result. Separately, i_rst asserted at beat 7 -> no output, no o_err, o_err_cnt==0.
- Range check (macro defined): word 3 = P -> no output; o_err pulses at eop. With the macro undefined, the same packet produces an output with word 3 == P.
